uart_rx_flow: RTL and testbench
===============================

Name: uart_rx_flow

Overview:
- UART receive stage feeding the bridge's frame parser.
- Samples the `uart_rx` pin and deserialises 8N1 bytes into a small FIFO.
- Drives the receive-side status signals: `rx_valid`, `rx_data`, `rx_error`, `frame_start`, `byte_received`.
- Drives the `uart_rts_n` hardware flow-control output from FIFO fill level, with hysteresis.

Parameters:
- FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 4.
- RTS_OFF_LEVEL, 12, FIFO count at or above which `uart_rts_n` deasserts (goes high).
- RTS_ON_LEVEL, 4, FIFO count at or below which `uart_rts_n` reasserts (goes low); must be less than RTS_OFF_LEVEL.
- MIN_DIVISOR, 4, floor applied to `baud_divisor`.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- uart_rx  input  1  serial line, asynchronous to `clk`, idles high.
- baud_divisor  input  16  clk cycles per bit; values below MIN_DIVISOR are treated as MIN_DIVISOR.
- rx_ready  input  1  consumer pops the FIFO head when `rx_ready` and `rx_valid` are both high.
- rx_data  output  8  FIFO head byte.
- rx_valid  output  1  FIFO not empty.
- rx_error  output  1  one-cycle pulse on framing error or overflow.
- frame_start  output  1  one-cycle pulse when a start bit is confirmed.
- byte_received  output  1  one-cycle pulse when a byte is written into the FIFO.
- uart_rts_n  output  1  active-low request-to-send.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `rx_error` = 0, `frame_start` = 0, `byte_received` = 0, `fifo_count` = 0.
  - `uart_rts_n` = 1; it goes low on the first clk edge after reset release.
  - Synchroniser flops reset to 1; FSM resets to IDLE.
- Input path: 2-flop synchroniser on `uart_rx`. All sampling uses the synchronised value `rxs`.
- Divisor: `baud_divisor` is latched into `div_q` on the IDLE->START transition. Changes mid-frame have no effect.
- FSM:
  - IDLE: on `rxs` 1->0 transition, go to START; bit counter loads `div_q/2` (integer divide, floor).
  - START: when the counter expires, if `rxs`==0, pulse `frame_start`, go to DATA, reload `div_q`, bit index = 0. If `rxs`==1 the start was a glitch: return to IDLE, no pulse.
  - DATA: at each counter expiry, shift `rxs` into bit [index], LSB first, and reload `div_q`. After bit 7 go to STOP.
  - STOP: at counter expiry, sample `rxs`:
    - `rxs`=1 and FIFO not full (or a pop in the same cycle): push byte, pulse `byte_received`, go to IDLE.
    - `rxs`=1 and FIFO full with no pop: drop byte, pulse `rx_error` (overflow), go to IDLE.
    - `rxs`=0: framing error; drop byte, pulse `rx_error`, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`==1, then go to IDLE. A break condition therefore yields exactly one error pulse.
- Counters count down from the loaded value; expiry is at count == 0.
- FIFO:
  - Synchronous circular buffer; read/write pointers wrap at FIFO_DEPTH.
  - `rx_data` is the registered head, valid whenever `rx_valid` = 1.
  - Push and pop in the same cycle: `fifo_count` unchanged; head advances.
  - Push when empty: `rx_valid` rises on the cycle after the STOP sample edge (latency 1).
  - Pop when empty is ignored.
- RTS hysteresis, registered:
  - When `fifo_count` >= RTS_OFF_LEVEL, `uart_rts_n` goes to 1.
  - When `fifo_count` <= RTS_ON_LEVEL, `uart_rts_n` goes to 0.
  - Between the two levels it holds its value.
  - Reception continues while `uart_rts_n`=1; overflow is handled as above.
- Reset mid-frame: partial byte discarded, FIFO cleared, all outputs return to reset values immediately (asynchronous).
- Simultaneous framing error and pop: pop proceeds; the error pulse is independent.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP, sampling one even-parity bit after bit 7.
  - On mismatch, the byte is dropped at STOP and `rx_error` pulses once (not twice if STOP also fails).
  - Adds output `parity_err` (1 bit), a one-cycle pulse coincident with `rx_error` for parity failures only.
- Undefined: 8N1 only; no PARITY state and no `parity_err` port.

Test Plan:
- Divisor 16, send 0xA5 8N1 -> `frame_start` pulse ~8 clk after the falling edge; `byte_received` pulse; `rx_valid`=1 with `rx_data`=0xA5 the next cycle; `fifo_count`=1; `rx_error` never high.
- Divisor 16, 4-clk low glitch on idle line -> no `frame_start`, FSM back in IDLE, `fifo_count`=0.
- Divisor 16, 0x3C sent with stop bit = 0, line held low 40 bit-times -> exactly one `rx_error` pulse, no push; next byte 0x55 received correctly after the line returns high.
- `rx_ready`=0, send 12 bytes 0x00..0x0B -> `uart_rts_n` rises when `fifo_count` hits 12. Pop 8 -> `uart_rts_n` falls at `fifo_count`=4. Popped data in order 0x00..0x07.
- Fill 16 bytes, send 17th (0xFF) with `rx_ready`=0 -> `rx_error` pulse, `fifo_count` stays 16, head still 0x00. Repeat with a pop coincident with the STOP sample -> 0xFF accepted, no error.
- Assert `rst`=0 during DATA bit 4 -> all outputs at reset values; after release, byte 0x81 received cleanly; divisor 3 behaves as 4.

Source files
------------

// File: rtl/uart_rx_flow.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------------------------
// uart_rx_flow : UART receiver (8N1) into a FIFO, RTS flow control with hysteresis.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.            Rev 1.0
// ------------------------------------------------------------------------------------------
module uart_rx_flow #(
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_OFF_LEVEL = 12,
  parameter int RTS_ON_LEVEL  = 4,
  parameter int MIN_DIVISOR   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic [15:0]                   baud_divisor,
  input  logic                          rx_ready,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          rx_error,
  output logic                          frame_start,
  output logic                          byte_received,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          uart_rts_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          sync1, rxs, rxs_prev;
  logic [15:0]   div_q, div_d, div_eff, cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          push, pop, full, expired, bad_parity;
  logic          start_d, err_d, rcv_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_d, perr_d;
  assign bad_parity = par_bad;
`else
  assign bad_parity = 1'b0;
`endif

  assign div_eff  = (baud_divisor < 16'(MIN_DIVISOR)) ? 16'(MIN_DIVISOR) : baud_divisor;
  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign pop      = rx_ready && rx_valid;
  assign rd_next  = rd_ptr + AW'(1);
  assign expired  = (cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= uart_rx;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      div_q         <= 16'(MIN_DIVISOR);
      cnt           <= 16'd0;
      idx           <= 3'd0;
      shift         <= 8'd0;
      frame_start   <= 1'b0;
      rx_error      <= 1'b0;
      byte_received <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      div_q         <= div_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      shift         <= shift_d;
      frame_start   <= start_d;
      rx_error      <= err_d;
      byte_received <= rcv_d;
`ifdef UART_RX_PARITY_EN
      par_bad       <= par_bad_d;
      parity_err    <= perr_d;
`endif
    end
  end

  // Reload with div_q-1 so consecutive expiries are exactly div_q clocks apart.
  always_comb begin
    state_d = state;
    div_d   = div_q;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    push    = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    rcv_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad;
    perr_d    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rxs_prev && !rxs) begin
          state_d = START;
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
        end
      end
      START: begin
        if (!expired) begin
          cnt_d = cnt - 16'd1;
        end else if (!rxs) begin
          start_d = 1'b1;
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_d = cnt - 16'd1;
        end else begin
          shift_d[idx] = rxs;
          cnt_d        = div_q - 16'd1;
          idx_d        = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expired) begin
          cnt_d = cnt - 16'd1;
        end else begin
          par_bad_d = ^{shift, rxs};
          cnt_d     = div_q - 16'd1;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!expired) begin
          cnt_d = cnt - 16'd1;
        end else if (bad_parity) begin
          // One error pulse covers both parity and a simultaneous bad stop bit.
          err_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b1;
`endif
          state_d = rxs ? IDLE : WAIT_IDLE;
        end else if (!rxs) begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end else if (!full || pop) begin
          push    = 1'b1;
          rcv_d   = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  // rx_data is a registered copy of the head so it never glitches through the memory mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_data    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        if (fifo_count > CW'(1)) rx_data <= mem[rd_next];
        else if (push)           rx_data <= shift;
      end else if (push && fifo_count == '0) begin
        rx_data <= shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    uart_rts_n <= 1'b1;
    else if (fifo_count >= CW'(RTS_OFF_LEVEL))   uart_rts_n <= 1'b1;
    else if (fifo_count <= CW'(RTS_ON_LEVEL))    uart_rts_n <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_flow.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_rx_flow : directed self-checking bench for uart_rx_flow.
module tb_uart_rx_flow;
  logic        clk = 1'b0, rst = 1'b0, uart_rx = 1'b1, rx_ready = 1'b0;
  logic [15:0] baud_divisor = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_error, frame_start, byte_received, uart_rts_n;
  logic [4:0]  fifo_count;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif
  int checks = 0, failures = 0;
  int cyc = 0, fall_cyc = 0, fs_cyc = 0, fs_cnt = 0, br_cnt = 0, err_cnt = 0;
  logic       br_valid = 1'b0;
  logic [7:0] br_data = 8'd0;

  uart_rx_flow dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .baud_divisor(baud_divisor),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .frame_start(frame_start), .byte_received(byte_received),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .uart_rts_n(uart_rts_n), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
      if (byte_received) begin br_cnt++; br_valid = rx_valid; br_data = rx_data; end
      if (rx_error) err_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame of bc clocks per bit; optional single-cycle pop ending on the STOP sample edge (bc=16).
  task automatic send_byte(input logic [7:0] d, input logic stop, input int bc, input bit pop_at_stop);
    tick(1);
    uart_rx = 1'b0;
    fall_cyc = cyc;
    tick(bc);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(bc);
    end
    uart_rx = stop;
    if (pop_at_stop) begin
      tick(3 + bc / 2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(bc - 4 - bc / 2);
    end else begin
      tick(bc);
    end
    tick(2 * bc);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0; baud_divisor = 16'd16;
    tick(3);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL reset_rx_error: got %b expected 0", rx_error); end
    checks++; if (frame_start !== 1'b0 || byte_received !== 1'b0) begin failures++; $display("FAIL reset_pulses: got fs=%b br=%b expected 0 0", frame_start, byte_received); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (uart_rts_n !== 1'b1) begin failures++; $display("FAIL reset_rts: got %b expected 1", uart_rts_n); end
    rst = 1'b1;
    checks++; if (uart_rts_n !== 1'b1) begin failures++; $display("FAIL rts_before_edge: got %b expected 1", uart_rts_n); end
    tick(1);
    checks++; if (uart_rts_n !== 1'b0) begin failures++; $display("FAIL rts_after_edge: got %b expected 0", uart_rts_n); end
    tick(4);
  endtask

  task automatic test_basic();
    int fs0 = fs_cnt, br0 = br_cnt, e0 = err_cnt;
    send_byte(8'hA5, 1'b1, 16, 1'b0);
    checks++; if (fs_cnt - fs0 != 1) begin failures++; $display("FAIL basic_frame_start_count: got %0d expected 1", fs_cnt - fs0); end
    checks++; if (fs_cyc - fall_cyc < 8 || fs_cyc - fall_cyc > 14) begin failures++; $display("FAIL basic_frame_start_delay: got %0d expected 8..14", fs_cyc - fall_cyc); end
    checks++; if (br_cnt - br0 != 1) begin failures++; $display("FAIL basic_byte_received: got %0d expected 1", br_cnt - br0); end
    checks++; if (br_valid !== 1'b1 || br_data !== 8'hA5) begin failures++; $display("FAIL basic_head: got valid=%b data=%h expected 1 a5", br_valid, br_data); end
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL basic_fifo_count: got %0d expected 1", fifo_count); end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL basic_no_error: got %0d errors expected 0", err_cnt - e0); end
    pop_one();
    checks++; if (rx_valid !== 1'b0 || fifo_count !== 5'd0) begin failures++; $display("FAIL basic_pop_empty: got valid=%b count=%0d expected 0 0", rx_valid, fifo_count); end
  endtask

  task automatic test_glitch();
    int fs0 = fs_cnt, e0 = err_cnt;
    tick(1);
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    checks++; if (fs_cnt != fs0) begin failures++; $display("FAIL glitch_frame_start: got %0d pulses expected 0", fs_cnt - fs0); end
    checks++; if (fifo_count !== 5'd0 || err_cnt != e0) begin failures++; $display("FAIL glitch_fifo: got count=%0d errs=%0d expected 0 0", fifo_count, err_cnt - e0); end
    send_byte(8'h5A, 1'b1, 16, 1'b0);
    checks++; if (fifo_count !== 5'd1 || rx_data !== 8'h5A) begin failures++; $display("FAIL glitch_recover: got count=%0d data=%h expected 1 5a", fifo_count, rx_data); end
    pop_one();
  endtask

  task automatic test_framing();
    int br0 = br_cnt, e0 = err_cnt;
    send_byte(8'h3C, 1'b0, 16, 1'b0);
    tick(40 * 16);
    uart_rx = 1'b1;
    tick(32);
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL framing_error_pulses: got %0d expected 1", err_cnt - e0); end
    checks++; if (br_cnt != br0 || fifo_count !== 5'd0) begin failures++; $display("FAIL framing_no_push: got br=%0d count=%0d expected 0 0", br_cnt - br0, fifo_count); end
    send_byte(8'h55, 1'b1, 16, 1'b0);
    checks++; if (fifo_count !== 5'd1 || rx_data !== 8'h55) begin failures++; $display("FAIL framing_next_byte: got count=%0d data=%h expected 1 55", fifo_count, rx_data); end
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL framing_extra_error: got %0d expected 1", err_cnt - e0); end
    pop_one();
  endtask

  task automatic test_rts();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(i), 1'b1, 16, 1'b0);
      if (i == 10) begin
        checks++; if (uart_rts_n !== 1'b0) begin failures++; $display("FAIL rts_low_at_11: got %b expected 0", uart_rts_n); end
      end
    end
    checks++; if (fifo_count !== 5'd12 || uart_rts_n !== 1'b1) begin failures++; $display("FAIL rts_high_at_12: got count=%0d rts=%b expected 12 1", fifo_count, uart_rts_n); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin failures++; $display("FAIL rts_pop_data[%0d]: got valid=%b data=%h expected 1 %h", i, rx_valid, rx_data, 8'(i)); end
      pop_one();
      if (i == 6) begin
        tick(2);
        checks++; if (uart_rts_n !== 1'b1) begin failures++; $display("FAIL rts_hold_at_5: got %b expected 1", uart_rts_n); end
      end
      if (i == 7) begin
        tick(2);
        checks++; if (fifo_count !== 5'd4 || uart_rts_n !== 1'b0) begin failures++; $display("FAIL rts_low_at_4: got count=%0d rts=%b expected 4 0", fifo_count, uart_rts_n); end
      end
    end
  endtask

  task automatic test_overflow();
    int br0, e0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 16, 1'b0);
    checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL ovf_full: got %0d expected 16", fifo_count); end
    br0 = br_cnt; e0 = err_cnt;
    send_byte(8'hFF, 1'b1, 16, 1'b0);
    checks++; if (err_cnt - e0 != 1 || br_cnt != br0) begin failures++; $display("FAIL ovf_drop: got errs=%0d br=%0d expected 1 0", err_cnt - e0, br_cnt - br0); end
    checks++; if (fifo_count !== 5'd16 || rx_data !== 8'h00) begin failures++; $display("FAIL ovf_state: got count=%0d head=%h expected 16 00", fifo_count, rx_data); end
    br0 = br_cnt; e0 = err_cnt;
    send_byte(8'hFF, 1'b1, 16, 1'b1);
    checks++; if (err_cnt != e0 || br_cnt - br0 != 1) begin failures++; $display("FAIL ovf_pop_accept: got errs=%0d br=%0d expected 0 1", err_cnt - e0, br_cnt - br0); end
    checks++; if (fifo_count !== 5'd16 || rx_data !== 8'h01) begin failures++; $display("FAIL ovf_pop_state: got count=%0d head=%h expected 16 01", fifo_count, rx_data); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 15) ? 8'hFF : 8'(i + 1);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_d) begin failures++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%h expected 1 %h", i, rx_valid, rx_data, exp_d); end
      pop_one();
    end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL ovf_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_reset_midframe();
    int br0, e0;
    send_byte(8'h11, 1'b1, 16, 1'b0);
    tick(1);
    uart_rx = 1'b0;
    tick(16 + 4 * 16 + 8);
    #3 rst = 1'b0;
    #1;
    checks++; if (fifo_count !== 5'd0 || rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_fifo: got count=%0d valid=%b expected 0 0", fifo_count, rx_valid); end
    checks++; if (rx_data !== 8'h00 || uart_rts_n !== 1'b1) begin failures++; $display("FAIL midrst_outputs: got data=%h rts=%b expected 00 1", rx_data, uart_rts_n); end
    checks++; if (rx_error !== 1'b0 || frame_start !== 1'b0 || byte_received !== 1'b0) begin failures++; $display("FAIL midrst_pulses: got %b%b%b expected 000", rx_error, frame_start, byte_received); end
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(10);
    baud_divisor = 16'd3;
    br0 = br_cnt; e0 = err_cnt;
    send_byte(8'h81, 1'b1, 4, 1'b0);
    checks++; if (br_cnt - br0 != 1 || err_cnt != e0) begin failures++; $display("FAIL div3_pulses: got br=%0d errs=%0d expected 1 0", br_cnt - br0, err_cnt - e0); end
    checks++; if (fifo_count !== 5'd1 || rx_data !== 8'h81) begin failures++; $display("FAIL div3_data: got count=%0d data=%h expected 1 81", fifo_count, rx_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_rts();
    test_overflow();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
